// File: rtl/uart_rx_fifo_if.sv
// Line-side and register-side signals of the buffered UART receiver.
// state_dbg encodes the receiver FSM (0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK); count_dbg is FIFO occupancy.
interface uart_rx_fifo_if;
  logic       rx;
  logic       data_read;
  logic [7:0] rxdata;
  logic       rxrecv;
  logic       rts;
  logic       overrun;
  logic       framing_err;
  logic [2:0] state_dbg;
  logic [4:0] count_dbg;

  // Handshake: rxdata is valid while rxrecv=1; data_read is a level strobe and the
  // head byte is consumed on its falling edge, so rxdata holds for the whole access.
  modport master (
    output rx, data_read,
    input  rxdata, rxrecv, rts, overrun, framing_err, state_dbg, count_dbg
  );
  modport slave (
    input  rx, data_read,
    output rxdata, rxrecv, rts, overrun, framing_err, state_dbg, count_dbg
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a 16-entry show-ahead FIFO with RTS hysteresis.
// Optional feature macro: UART_RX_GLITCH_FILTER_EN (2-of-3 majority bit sampling).
module uart_rx_fifo #(
  parameter int CLK = 24000000,
  parameter int BPS = 115200
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int          DIVISOR   = (CLK + BPS / 2) / BPS;
  localparam logic [15:0] DIV_LOAD  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LOAD = 16'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        sync1, rxs;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bitn, bitn_n;
  logic [7:0]  shreg, shreg_n;
  logic        counting, tick, bit_val;
  logic        push, ferr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
    end
  end

  assign counting = (state == START) || (state == DATA) || (state == STOP);

`ifdef UART_RX_GLITCH_FILTER_EN
  // Decision lands one cycle after expiry so the +1 sample is available.
  logic rxs_d1, rxs_d2, tick_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
      tick_q <= counting && (cnt == 16'd0);
    end
  end
  assign tick    = tick_q;
  assign bit_val = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign tick    = counting && (cnt == 16'd0);
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      bitn  <= 3'd0;
      shreg <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    // Free-running bit timer reloads at every expiry so sample spacing stays DIVISOR.
    if (counting) cnt_n = (cnt == 16'd0) ? DIV_LOAD : cnt - 16'd1;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (bit_val) begin
            state_n = IDLE;
          end else begin
            bitn_n  = 3'd0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = {bit_val, shreg[7:1]};
          bitn_n  = bitn + 3'd1;
          if (bitn == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_val) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0] mem [16];
  logic [3:0] wptr, rptr;
  logic [4:0] count;
  logic       dr_q, rts_q, ovr_q, ferr_q;
  logic       pop_evt, pop, full, do_push, ovr_set;

  assign pop_evt = dr_q & ~bus.data_read;
  assign pop     = pop_evt && (count != 5'd0);
  assign full    = (count == 5'd16);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      wptr   <= 4'd0;
      rptr   <= 4'd0;
      count  <= 5'd0;
      dr_q   <= 1'b0;
      rts_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      dr_q <= bus.data_read;
      if (do_push) begin
        mem[wptr] <= shreg;
        wptr      <= wptr + 4'd1;
      end
      if (pop) rptr <= rptr + 4'd1;
      if (do_push && !pop)      count <= count + 5'd1;
      else if (pop && !do_push) count <= count - 5'd1;
      if (count >= 5'd12)     rts_q <= 1'b1;
      else if (count <= 5'd8) rts_q <= 1'b0;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (pop_evt) ovr_q <= 1'b0;
      if (ferr_set)     ferr_q <= 1'b1;
      else if (pop_evt) ferr_q <= 1'b0;
    end
  end

  assign bus.rxdata      = mem[rptr];
  assign bus.rxrecv      = (count != 5'd0);
  assign bus.rts         = rts_q;
  assign bus.overrun     = ovr_q;
  assign bus.framing_err = ferr_q;
  assign bus.state_dbg   = state;
  assign bus.count_dbg   = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames in, FIFO reads out, against a queue model.
module tb_uart_rx_fifo;
  localparam int DIV  = (24000000 + 115200 / 2) / 115200;
  localparam int HALF = DIV / 2;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int LAT = 1981;
`else
  localparam int LAT = 1980;
`endif
  // Frames are driven just after an edge; the byte lands in the FIFO on edge LAT-1 after that one.
  localparam int PUSH_EDGE = LAT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] exp_q[$];
  logic       m_rts = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_fifo_if ifc();
  uart_rx_fifo dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded 90000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: FIFO as a queue, RTS hysteresis on occupancy, sticky flags.
  task automatic m_rts_update();
    if (exp_q.size() >= 12)     m_rts = 1'b1;
    else if (exp_q.size() <= 8) m_rts = 1'b0;
  endtask

  task automatic m_push(input logic [7:0] b);
    if (exp_q.size() < 16) exp_q.push_back(b);
    else                   m_ovr = 1'b1;
    m_rts_update();
  endtask

  task automatic m_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_rts_update();
  endtask

  // Caller is just after a clock edge; each bit lasts exactly DIV cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic glitch);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ifc.rx = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        repeat (HALF) @(posedge clk);
        #1 ifc.rx = ~bits[i];
        @(posedge clk);
        #1 ifc.rx = bits[i];
        repeat (DIV - HALF - 1) @(posedge clk);
        #1;
      end else begin
        repeat (DIV) @(posedge clk);
        #1;
      end
    end
  endtask

  // Full register read: sample head, strobe 3 cycles, release, let rts settle.
  task automatic do_read(output logic [7:0] got);
    got = ifc.rxdata;
    ifc.data_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 ifc.data_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_pop();
  endtask

  task automatic test_reset();
    ifc.rx = 1'b1;
    ifc.data_read = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ifc.rxdata !== 8'h00) begin failures++; $display("FAIL reset_rxdata: got %h want 00", ifc.rxdata); end
    checks++; if (ifc.rxrecv !== 1'b0) begin failures++; $display("FAIL reset_rxrecv: got %b want 0", ifc.rxrecv); end
    checks++; if ({ifc.rts, ifc.overrun, ifc.framing_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {ifc.rts, ifc.overrun, ifc.framing_err}); end
    checks++; if (ifc.state_dbg !== 3'd0 || ifc.count_dbg !== 5'd0) begin failures++; $display("FAIL reset_state: got state %0d count %0d want 0 0", ifc.state_dbg, ifc.count_dbg); end
  endtask

  task automatic test_single_byte();
    int t0, lat;
    bit bad;
    @(posedge clk);
    #1;
    t0 = cyc;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 3000 && lat < 0; i++) begin
          @(negedge clk);
          if (ifc.rxrecv === 1'b1) lat = cyc - t0;
        end
      end
    join
    m_push(8'hA5);
    checks++; if (lat < LAT - 1 || lat > LAT + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d+-1 (-1 = timeout)", lat, LAT); end
    checks++; if (ifc.rxdata !== exp_q[0]) begin failures++; $display("FAIL single_data: got %h want %h", ifc.rxdata, exp_q[0]); end
    bad = 1'b0;
    ifc.data_read = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ifc.rxdata !== 8'hA5) bad = 1'b1;
      @(posedge clk);
    end
    #1 ifc.data_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_pop();
    checks++; if (bad) begin failures++; $display("FAIL single_stable: rxdata changed during read, want A5 held"); end
    checks++; if (ifc.rxrecv !== 1'b0) begin failures++; $display("FAIL single_pop: rxrecv got %b want 0", ifc.rxrecv); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_flow();
    logic [7:0] got, want;
    bit bad;
    @(posedge clk);
    #1;
    bad = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      m_push(8'(i));
      if (ifc.rts !== m_rts || ifc.count_dbg !== 5'(exp_q.size())) begin
        bad = 1'b1;
        $display("FAIL fill_step%0d: rts %b count %0d want rts %b count %0d", i, ifc.rts, ifc.count_dbg, m_rts, exp_q.size());
      end
    end
    checks++; if (bad) failures++;
    checks++; if (ifc.overrun !== m_ovr) begin failures++; $display("FAIL fill_overrun: got %b want %b", ifc.overrun, m_ovr); end
    want = exp_q[0];
    do_read(got);
    checks++; if (got !== want) begin failures++; $display("FAIL fill_first_read: got %h want %h", got, want); end
    checks++; if (ifc.overrun !== m_ovr) begin failures++; $display("FAIL fill_overrun_clear: got %b want %b", ifc.overrun, m_ovr); end
    send_frame(8'h11, 1'b1, 1'b0);
    m_push(8'h11);
    checks++; if (ifc.count_dbg !== 5'(exp_q.size()) || ifc.overrun !== m_ovr) begin failures++; $display("FAIL refill: count %0d ovr %b want %0d %b", ifc.count_dbg, ifc.overrun, exp_q.size(), m_ovr); end
    // Read access whose falling edge coincides with the stop-bit sample of 8'h12.
    want = exp_q[0];
    fork
      send_frame(8'h12, 1'b1, 1'b0);
      begin
        repeat (PUSH_EDGE - 5) @(posedge clk);
        #1 ifc.data_read = 1'b1;
        repeat (4) @(posedge clk);
        #1 got = ifc.rxdata;
        ifc.data_read = 1'b0;
      end
    join
    m_pop();
    m_push(8'h12);
    checks++; if (got !== want) begin failures++; $display("FAIL full_pop_data: got %h want %h", got, want); end
    checks++; if (ifc.count_dbg !== 5'(exp_q.size()) || ifc.overrun !== m_ovr) begin failures++; $display("FAIL full_push_pop: count %0d ovr %b want %0d %b", ifc.count_dbg, ifc.overrun, exp_q.size(), m_ovr); end
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      want = exp_q[0];
      do_read(got);
      if (got !== want || ifc.rts !== m_rts) begin
        bad = 1'b1;
        $display("FAIL drain_read%0d: data %h rts %b want %h %b", i, got, ifc.rts, want, m_rts);
      end
    end
    checks++; if (bad) failures++;
    checks++; if (ifc.rxrecv !== 1'b0) begin failures++; $display("FAIL drain_empty: rxrecv got %b want 0", ifc.rxrecv); end
  endtask

  task automatic test_framing();
    logic [7:0] got;
    bit bad;
    send_frame(8'h3C, 1'b0, 1'b0);
    m_ferr = 1'b1;
    bad = 1'b0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (ifc.rxrecv !== 1'b0 || ifc.state_dbg !== 3'd4) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL framing_hold: push or restart while line low, want BREAK and empty"); end
    checks++; if (ifc.framing_err !== m_ferr) begin failures++; $display("FAIL framing_flag: got %b want %b", ifc.framing_err, m_ferr); end
    @(posedge clk);
    #1 ifc.rx = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    send_frame(8'h55, 1'b1, 1'b0);
    m_push(8'h55);
    checks++; if (ifc.rxrecv !== 1'b1 || ifc.rxdata !== exp_q[0]) begin failures++; $display("FAIL framing_next: rxrecv %b data %h want 1 %h", ifc.rxrecv, ifc.rxdata, exp_q[0]); end
    do_read(got);
    checks++; if (ifc.framing_err !== m_ferr) begin failures++; $display("FAIL framing_clear: got %b want %b", ifc.framing_err, m_ferr); end
  endtask

  task automatic test_false_start();
    ifc.rx = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1 ifc.rx = 1'b1;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    checks++; if (ifc.state_dbg !== 3'd0 || ifc.rxrecv !== 1'b0) begin failures++; $display("FAIL false_start: state %0d rxrecv %b want 0 0", ifc.state_dbg, ifc.rxrecv); end
    checks++; if ({ifc.overrun, ifc.framing_err, ifc.rts} !== {m_ovr, m_ferr, m_rts}) begin failures++; $display("FAIL false_start_flags: got %b want %b", {ifc.overrun, ifc.framing_err, ifc.rts}, {m_ovr, m_ferr, m_rts}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    logic [7:0] got, want;
`ifdef UART_RX_GLITCH_FILTER_EN
    want = 8'hF0;
`else
    // An unfiltered sample at the glitch instant reads every data bit inverted.
    want = ~8'hF0;
`endif
    send_frame(8'hF0, 1'b1, 1'b1);
    m_push(want);
    do_read(got);
    checks++; if (got !== want) begin failures++; $display("FAIL glitch_data: got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, want, b;
    int n;
    bit bad;
    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      m_push(b);
    end
    checks++; if (ifc.count_dbg !== 5'(exp_q.size())) begin failures++; $display("FAIL b2b_count: got %0d want %0d", ifc.count_dbg, exp_q.size()); end
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      want = exp_q[0];
      do_read(got);
      if (got !== want) begin
        bad = 1'b1;
        $display("FAIL b2b_read%0d: got %h want %h", i, got, want);
      end
    end
    checks++; if (bad) failures++;
    checks++; if (ifc.rxrecv !== 1'b0) begin failures++; $display("FAIL b2b_empty: rxrecv got %b want 0", ifc.rxrecv); end
  endtask

  initial begin
    ifc.rx = 1'b1;
    ifc.data_read = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_flow();
    test_framing();
    test_false_start();
    test_glitch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
